ball_motion: RTL

Per-frame ball physics and sprite-hit block for the 800x600 VGA game. It replaces the fixed, single-axis speed logic with signed two-axis velocity, push-button kicks, deceleration toward zero, wall clamping and optional bounce. It also produces a registered ball pixel mask for the RGB mux. The block sits between the VGA timing generator (`h_coord`/`v_coord`) and the colour output stage.

---
 rtl/ball_pkg.sv | 18 +
 rtl/ball_motion_frame_tick.sv | 38 +++
 rtl/ball_motion.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// Shared types and screen defaults for the ball physics block.
package ball_pkg;

    localparam int H_ACTIVE_DFLT   = 800;
    localparam int V_ACTIVE_DFLT   = 600;
    localparam int KICK_SPEED_DFLT = 8;
    localparam int VEL_W_DFLT      = $clog2(KICK_SPEED_DFLT + 1) + 1;

    typedef enum logic [1:0] {
        S_WAIT,
        S_ACCEL,
        S_MOVE,
        S_BOUNCE
    } ball_state_e;

    typedef logic signed [VEL_W_DFLT-1:0] vel_t;

endpackage

// File: rtl/ball_motion_frame_tick.sv
// End-of-frame tick with a FRAMES_PER_ACTION divider; update_tick fires on the
// first tick of each group of frames.
module frame_tick_gen #(
    parameter int COORD_W           = 10,
    parameter int H_ACTIVE          = 800,
    parameter int V_ACTIVE          = 600,
    parameter int FRAMES_PER_ACTION = 2
) (
    input  logic               pixel_clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] h_coord,
    input  logic [COORD_W-1:0] v_coord,
    output logic               update_tick
);

    localparam int DIV_W = (FRAMES_PER_ACTION > 1) ? $clog2(FRAMES_PER_ACTION) : 1;
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_ACTIVE - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(FRAMES_PER_ACTION - 1);

    logic             frame_tick;
    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick <= 1'b0;
            div_cnt    <= '0;
        end else begin
            frame_tick <= (h_coord == H_LAST) && (v_coord == V_LAST);
            // every tick advances the divider, whether or not an update is running
            if (frame_tick)
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    assign update_tick = frame_tick && (div_cnt == '0);

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball physics (kick, decay, move, wall clamp) and registered sprite mask.
// Define BALL_BOUNCE_EN to reflect velocity on a wall hit instead of stopping.
module ball_motion
    import ball_pkg::*;
#(
    parameter  int COORD_W           = 10,
    parameter  int H_ACTIVE          = H_ACTIVE_DFLT,
    parameter  int V_ACTIVE          = V_ACTIVE_DFLT,
    parameter  int BALL_SIZE         = 16,
    parameter  int KICK_SPEED        = KICK_SPEED_DFLT,
    parameter  int DECEL             = 1,
    parameter  int FRAMES_PER_ACTION = 2,
    localparam int SPD_W             = $clog2(KICK_SPEED + 1) + 1
) (
    input  logic                      pixel_clk,
    input  logic                      rst_n,
    input  logic                      button_c,
    input  logic                      button_u,
    input  logic                      button_d,
    input  logic                      button_l,
    input  logic                      button_r,
    input  logic [COORD_W-1:0]        h_coord,
    input  logic [COORD_W-1:0]        v_coord,
    output logic [COORD_W-1:0]        ball_x,
    output logic [COORD_W-1:0]        ball_y,
    output logic signed [SPD_W-1:0]   vel_x,
    output logic signed [SPD_W-1:0]   vel_y,
    output logic                      ball_pix,
    output logic                      update_done
);

    localparam int PW = COORD_W + 2;

    localparam logic signed [SPD_W-1:0] KICK_POS = SPD_W'(KICK_SPEED);
    localparam logic signed [SPD_W-1:0] KICK_NEG = SPD_W'(-KICK_SPEED);
    localparam logic signed [SPD_W-1:0] DECEL_V  = SPD_W'(DECEL);
    localparam logic signed [PW-1:0]    X_LIM    = PW'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [PW-1:0]    Y_LIM    = PW'(V_ACTIVE - BALL_SIZE);
    localparam logic [COORD_W-1:0]      X_LIM_C  = COORD_W'(H_ACTIVE - BALL_SIZE);
    localparam logic [COORD_W-1:0]      Y_LIM_C  = COORD_W'(V_ACTIVE - BALL_SIZE);
    localparam logic [COORD_W-1:0]      X_RST    = COORD_W'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0]      Y_RST    = COORD_W'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [COORD_W:0]        SIZE_E   = (COORD_W+1)'(BALL_SIZE);

    ball_state_e state, state_nx;
    logic                     update_tick;
    logic signed [SPD_W-1:0]  acc_vx, acc_vy;
    logic signed [SPD_W-1:0]  wall_vx, wall_vy;
    logic signed [PW-1:0]     sum_x, sum_y;
    logic [COORD_W:0]         x_end, y_end;

    frame_tick_gen #(
        .COORD_W          (COORD_W),
        .H_ACTIVE         (H_ACTIVE),
        .V_ACTIVE         (V_ACTIVE),
        .FRAMES_PER_ACTION(FRAMES_PER_ACTION)
    ) u_tick (
        .pixel_clk  (pixel_clk),
        .rst_n      (rst_n),
        .h_coord    (h_coord),
        .v_coord    (v_coord),
        .update_tick(update_tick)
    );

    // Magnitude shrinks by DECEL and saturates at zero without crossing sign.
    function automatic logic signed [SPD_W-1:0] decay(input logic signed [SPD_W-1:0] v);
        if (v > DECEL_V)
            return v - DECEL_V;
        else if (v < -DECEL_V)
            return v + DECEL_V;
        else
            return '0;
    endfunction

    function automatic logic signed [PW-1:0] pos_ext(input logic [COORD_W-1:0] p);
        return $signed({2'b00, p});
    endfunction

    function automatic logic signed [PW-1:0] vel_ext(input logic signed [SPD_W-1:0] v);
        return $signed({{(PW-SPD_W){v[SPD_W-1]}}, v});
    endfunction

`ifdef BALL_BOUNCE_EN
    assign wall_vx = -acc_vx;
    assign wall_vy = -acc_vy;
`else
    assign wall_vx = '0;
    assign wall_vy = '0;
`endif

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_WAIT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_WAIT:   if (update_tick) state_nx = S_ACCEL;
            S_ACCEL:  state_nx = S_MOVE;
            S_MOVE:   state_nx = S_BOUNCE;
            S_BOUNCE: state_nx = S_WAIT;
            default:  state_nx = S_WAIT;
        endcase
    end

    assign x_end = {1'b0, ball_x} + SIZE_E;
    assign y_end = {1'b0, ball_y} + SIZE_E;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            ball_x      <= X_RST;
            ball_y      <= Y_RST;
            vel_x       <= '0;
            vel_y       <= '0;
            acc_vx      <= '0;
            acc_vy      <= '0;
            sum_x       <= '0;
            sum_y       <= '0;
            ball_pix    <= 1'b0;
            update_done <= 1'b0;
        end else begin
            update_done <= 1'b0;
            ball_pix    <= (h_coord >= ball_x) && ({1'b0, h_coord} < x_end) &&
                           (v_coord >= ball_y) && ({1'b0, v_coord} < y_end);
            case (state)
                S_ACCEL: begin
                    if (button_c) begin
                        acc_vx <= '0;
                        acc_vy <= '0;
                    end else begin
                        if (button_l)      acc_vx <= KICK_NEG;
                        else if (button_r) acc_vx <= KICK_POS;
                        else               acc_vx <= decay(vel_x);
                        if (button_u)      acc_vy <= KICK_NEG;
                        else if (button_d) acc_vy <= KICK_POS;
                        else               acc_vy <= decay(vel_y);
                    end
                end
                S_MOVE: begin
                    sum_x <= pos_ext(ball_x) + vel_ext(acc_vx);
                    sum_y <= pos_ext(ball_y) + vel_ext(acc_vy);
                end
                S_BOUNCE: begin
                    // committed right after the last active pixel, so inside blanking
                    update_done <= 1'b1;
                    if (sum_x[PW-1]) begin
                        ball_x <= '0;
                        vel_x  <= wall_vx;
                    end else if (sum_x > X_LIM) begin
                        ball_x <= X_LIM_C;
                        vel_x  <= wall_vx;
                    end else begin
                        ball_x <= sum_x[COORD_W-1:0];
                        vel_x  <= acc_vx;
                    end
                    if (sum_y[PW-1]) begin
                        ball_y <= '0;
                        vel_y  <= wall_vy;
                    end else if (sum_y > Y_LIM) begin
                        ball_y <= Y_LIM_C;
                        vel_y  <= wall_vy;
                    end else begin
                        ball_y <= sum_y[COORD_W-1:0];
                        vel_y  <= acc_vy;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
